fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side pointer/flag controller of the async FIFO, running in the read clock domain. It owns the binary read pointer and presents the read address and read enable to the dual-port FIFO memory. It produces a registered Gray-coded read pointer for the write-domain synchronizer. It derives the empty, almost-empty and fill-level indications from the already-synchronized Gray write pointer.

Parameters:
PTR_WIDTH, 4, pointer width; one extra MSB distinguishes wrap, so FIFO depth = 2^(PTR_WIDTH-1) (8 by default).
AE_LEVEL, 1, ralmost_empty asserts when the fill level is <= AE_LEVEL.

Ports:
rclk  input  1  read clock.
rrst  input  1  asynchronous reset, active-high.
rinc  input  1  read request from the consumer; honoured only when rempty=0.
synced_wr_ptr  input  PTR_WIDTH  Gray write pointer, already synchronized into rclk.
rptr_grey  output  PTR_WIDTH  registered Gray read pointer, sent to the write-domain synchronizer.
raddr  output  PTR_WIDTH-1  memory read address = rptr[PTR_WIDTH-2:0].
rd_en  output  1  memory read enable = rinc & ~rempty (combinational).
rempty  output  1  registered empty flag.
ralmost_empty  output  1  registered; fill level <= AE_LEVEL.
rcount  output  PTR_WIDTH  registered fill level, 0..depth.
rvalid  output  1  one-cycle pulse, asserted in the cycle after each accepted read (aligned to synchronous-read memory data).
runderflow  output  1  sticky error flag; set by a read attempt while empty.

Behaviour:
- Reset (rrst=1, asynchronous, any cycle including mid-transfer):
  - rptr=0, rptr_grey=0, raddr=0.
  - rempty=1, ralmost_empty=1, rcount=0.
  - rvalid=0, runderflow=0.
  - rd_en=0 follows from rempty=1.
- rd_fire = rinc & ~rempty. rptr_next = rptr + rd_fire, modulo 2^PTR_WIDTH; wrap is natural.
- Gray encode: bin2gray(x) = x ^ (x>>1). It is generic over PTR_WIDTH; no lookup table.
- On each rclk edge:
  - rptr <= rptr_next.
  - rptr_grey <= bin2gray(rptr_next). Gray and binary pointers therefore change on the same edge.
- Empty: rempty <= (bin2gray(rptr_next) == synced_wr_ptr).
  - Comparison is on all PTR_WIDTH bits.
  - Empty deasserts one rclk after synced_wr_ptr advances.
  - Empty asserts on the same edge that consumes the last word, so there is no read-past-empty window.
- Fill level:
  - wr_bin = gray2bin(synced_wr_ptr), where bit i = XOR of bits PTR_WIDTH-1..i.
  - rcount <= wr_bin - rptr_next, PTR_WIDTH-bit modular subtraction.
  - Max legal value is depth (8), e.g. wr=1000 / rd=0000.
- ralmost_empty <= (wr_bin - rptr_next) <= AE_LEVEL.
- rvalid <= rd_fire.
- runderflow:
  - Set when rinc & rempty.
  - Cleared only by reset.
  - An underflow attempt leaves the pointer, raddr and flags unchanged, and rd_en stays 0.
- Simultaneous read and write advance in the same cycle: rcount is unchanged; rempty is evaluated against the new values of both pointers.
- Flags are conservative because synced_wr_ptr lags by the synchronizer latency. rempty may stay high for extra cycles but is never falsely low.
- No protection against illegal synced_wr_ptr (distance > depth); the behaviour is undefined and is not checked.
- Purely single-clock synchronous logic apart from the async reset; no combinational path from synced_wr_ptr to any output.

Test Plan:
1. Assert rrst for 2 cycles, then release -> rempty=1, ralmost_empty=1, rptr_grey=0000, raddr=000, rcount=0, rvalid=0, runderflow=0. Assert rrst again mid-stream -> all outputs return to these values immediately, without waiting for an rclk edge.
2. Set synced_wr_ptr=0010 (binary 3), rinc=0 -> after 1 edge: rempty=0, rcount=3, ralmost_empty=0. Then rinc=1 for 3 cycles:
   - raddr = 000, 001, 010, with rd_en=1 each cycle.
   - rvalid high in the cycle after each read.
   - rcount goes 2, 1, 0; ralmost_empty=1 from rcount=1.
   - After the 3rd read: rempty=1, rptr_grey=0010.
3. With rempty=1, hold rinc=1 -> rd_en=0, raddr unchanged, runderflow=1 from the next cycle and stays high after rinc drops until rrst.
4. Full drain: set synced_wr_ptr=1100 (binary 8) with rptr=0 -> rcount=8, rempty=0. Read 8 -> raddr walks 000..111, final rptr_grey=1100, rempty=1, rcount=0.
5. Wrap: continue with synced_wr_ptr=1000 (binary 15, pointer wrapped) and 7 reads from rptr=8 -> rptr 15, rptr_grey=1000, raddr=111, rempty=1. Then set synced_wr_ptr=0000 and do 1 read -> rptr_grey wraps to 0000, raddr=000, rempty=1.
6. Simultaneous events: with rcount=2, advance synced_wr_ptr by one Gray step in the same cycle as rinc=1 -> rcount stays 2, rempty=0, raddr increments by 1.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: consumer request, synced write pointer in;
// memory control, Gray pointer and flags out.
interface fifo_rd_ctrl_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 rinc;
  logic [PTR_WIDTH-1:0] synced_wr_ptr;
  logic [PTR_WIDTH-1:0] rptr_grey;
  logic [PTR_WIDTH-2:0] raddr;
  logic                 rd_en;
  logic                 rempty;
  logic                 ralmost_empty;
  logic [PTR_WIDTH-1:0] rcount;
  logic                 rvalid;
  logic                 runderflow;

  modport master (
    output rinc, synced_wr_ptr,
    input  rptr_grey, raddr, rd_en, rempty, ralmost_empty, rcount, rvalid, runderflow
  );

  modport slave (
    input  rinc, synced_wr_ptr,
    output rptr_grey, raddr, rd_en, rempty, ralmost_empty, rcount, rvalid, runderflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: binary/Gray read pointer, empty,
// almost-empty and fill level derived from the synchronized Gray write pointer.
module fifo_rd_ctrl #(
  parameter int PTR_WIDTH = 4,
  parameter int AE_LEVEL  = 1
) (
  input  logic          rclk,
  input  logic          rrst,
  fifo_rd_ctrl_if.slave bus
);

  localparam int W = PTR_WIDTH;

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [W-1:0] rptr, rptr_next, wr_bin, fill_next;
  logic         rd_fire;

  // Reads are gated by the registered empty flag, so no read-past-empty.
  assign rd_fire   = bus.rinc & ~bus.rempty;
  assign rptr_next = rptr + W'(rd_fire);
  assign wr_bin    = gray2bin(bus.synced_wr_ptr);
  assign fill_next = wr_bin - rptr_next;

  assign bus.raddr = rptr[W-2:0];
  assign bus.rd_en = rd_fire;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr              <= '0;
      bus.rptr_grey     <= '0;
      bus.rempty        <= 1'b1;
      bus.ralmost_empty <= 1'b1;
      bus.rcount        <= '0;
      bus.rvalid        <= 1'b0;
      bus.runderflow    <= 1'b0;
    end else begin
      rptr              <= rptr_next;
      bus.rptr_grey     <= bin2gray(rptr_next);
      bus.rempty        <= (bin2gray(rptr_next) == bus.synced_wr_ptr);
      bus.ralmost_empty <= (fill_next <= W'(AE_LEVEL));
      bus.rcount        <= fill_next;
      bus.rvalid        <= rd_fire;
      if (bus.rinc && bus.rempty) bus.runderflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with hand-computed expectations.
module tb_fifo_rd_ctrl;
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 rclk = ~rclk;

  fifo_rd_ctrl_if #(.PTR_WIDTH(4)) bus ();

  fifo_rd_ctrl #(.PTR_WIDTH(4), .AE_LEVEL(1)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rempty"}, 32'(bus.rempty), 1);
    chk({tag, ".ae"},     32'(bus.ralmost_empty), 1);
    chk({tag, ".grey"},   32'(bus.rptr_grey), 0);
    chk({tag, ".raddr"},  32'(bus.raddr), 0);
    chk({tag, ".rcount"}, 32'(bus.rcount), 0);
    chk({tag, ".rvalid"}, 32'(bus.rvalid), 0);
    chk({tag, ".unf"},    32'(bus.runderflow), 0);
    chk({tag, ".rd_en"},  32'(bus.rd_en), 0);
  endtask

  initial begin
    bus.rinc = 1'b0;
    bus.synced_wr_ptr = 4'b0000;

    // 1. reset
    rrst = 1'b1;
    step(); step();
    rrst = 1'b0;
    step();
    chk_reset_vals("rst");

    // 2. three words available
    bus.synced_wr_ptr = 4'b0010;
    step();
    chk("t2.rempty", 32'(bus.rempty), 0);
    chk("t2.rcount", 32'(bus.rcount), 3);
    chk("t2.ae",     32'(bus.ralmost_empty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2.raddr", 32'(bus.raddr), 32'(i));
      chk("t2.rd_en", 32'(bus.rd_en), 1);
      step();
      chk("t2.rvalid", 32'(bus.rvalid), 1);
      chk("t2.rcount", 32'(bus.rcount), 32'(2 - i));
      chk("t2.ae",     32'(bus.ralmost_empty), (2 - i) <= 1 ? 1 : 0);
    end
    chk("t2.rempty_end", 32'(bus.rempty), 1);
    chk("t2.grey_end",   32'(bus.rptr_grey), 32'h2);

    // 3. underflow attempt (rinc still high, FIFO empty)
    #1;
    chk("t3.rd_en", 32'(bus.rd_en), 0);
    step();
    chk("t3.unf",   32'(bus.runderflow), 1);
    chk("t3.raddr", 32'(bus.raddr), 3);
    chk("t3.rvalid", 32'(bus.rvalid), 0);
    chk("t3.grey",  32'(bus.rptr_grey), 32'h2);
    bus.rinc = 1'b0;
    step(); step();
    chk("t3.unf_sticky", 32'(bus.runderflow), 1);

    // mid-stream async reset, observed before any clock edge
    #2;
    rrst = 1'b1;
    #1;
    chk_reset_vals("arst");
    step();
    rrst = 1'b0;

    // 4. full drain of 8 words
    bus.synced_wr_ptr = 4'b1100;
    step();
    chk("t4.rcount", 32'(bus.rcount), 8);
    chk("t4.rempty", 32'(bus.rempty), 0);
    chk("t4.ae",     32'(bus.ralmost_empty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4.raddr", 32'(bus.raddr), 32'(i));
      chk("t4.rd_en", 32'(bus.rd_en), 1);
      step();
      chk("t4.rcount", 32'(bus.rcount), 32'(7 - i));
    end
    bus.rinc = 1'b0;
    chk("t4.grey",   32'(bus.rptr_grey), 32'hC);
    chk("t4.rempty", 32'(bus.rempty), 1);
    chk("t4.rcount0", 32'(bus.rcount), 0);

    // 5. wrap: write pointer at binary 15, read from 8
    bus.synced_wr_ptr = 4'b1000;
    step();
    chk("t5.rcount", 32'(bus.rcount), 7);
    chk("t5.rempty", 32'(bus.rempty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t5.raddr", 32'(bus.raddr), 32'(i));
      step();
    end
    bus.rinc = 1'b0;
    chk("t5.grey",   32'(bus.rptr_grey), 32'h8);
    chk("t5.raddr7", 32'(bus.raddr), 7);
    chk("t5.rempty", 32'(bus.rempty), 1);
    bus.synced_wr_ptr = 4'b0000;
    step();
    chk("t5.rcount1", 32'(bus.rcount), 1);
    chk("t5.ae1",     32'(bus.ralmost_empty), 1);
    chk("t5.rempty1", 32'(bus.rempty), 0);
    bus.rinc = 1'b1;
    #1;
    chk("t5.rd_en", 32'(bus.rd_en), 1);
    step();
    bus.rinc = 1'b0;
    chk("t5.grey_wrap",  32'(bus.rptr_grey), 0);
    chk("t5.raddr_wrap", 32'(bus.raddr), 0);
    chk("t5.rempty_wrap", 32'(bus.rempty), 1);
    chk("t5.rvalid",     32'(bus.rvalid), 1);

    // 6. simultaneous read and write advance
    bus.synced_wr_ptr = 4'b0011;
    step();
    chk("t6.rcount_pre", 32'(bus.rcount), 2);
    bus.synced_wr_ptr = 4'b0010;
    bus.rinc = 1'b1;
    step();
    bus.rinc = 1'b0;
    chk("t6.rcount", 32'(bus.rcount), 2);
    chk("t6.rempty", 32'(bus.rempty), 0);
    chk("t6.raddr",  32'(bus.raddr), 1);
    chk("t6.grey",   32'(bus.rptr_grey), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end
endmodule
